keypad_scanner: RTL and testbench

Scans a 3-column by 4-row matrix keypad, synchronizes and debounces the row returns, and emits each new key press as a one-hot 12-bit code with a single-cycle `valid` strobe. It is the stage directly upstream of the `Display` block: its `Scan_data` and `valid` outputs connect one-to-one to the `Display` inputs of the same names.

---
 rtl/keypad_pkg.sv | 55 +++++
 rtl/keypad_row_sync.sv | 27 ++
 rtl/keypad_scanner.sv | 127 ++++++++++++
 tb/tb_keypad_scanner.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 3x4 matrix keypad scanner.
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 3;
  localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;

  // Scanner FSM states, with explicit encodings so waveforms stay readable.
  typedef enum logic [1:0] {
    SCAN         = 2'd0,
    DEBOUNCE     = 2'd1,
    EMIT         = 2'd2,
    WAIT_RELEASE = 2'd3
  } state_e;

  // Key indices for the bottom row; bits 0-8 are keys '1'-'9'.
  localparam int KEY_STAR = 9;
  localparam int KEY_0    = 10;
  localparam int KEY_HASH = 11;

  // Column driven first after reset.
  localparam logic [NUM_COLS-1:0] COL_RESET = 3'b001;

  // True when exactly one row return is high.
  function automatic logic is_single_row(input logic [NUM_ROWS-1:0] r);
    return (r == 4'b0001) || (r == 4'b0010) || (r == 4'b0100) || (r == 4'b1000);
  endfunction

  // Encode a one-hot row vector to its index (input is assumed one-hot).
  function automatic logic [1:0] row_index(input logic [NUM_ROWS-1:0] r);
    logic [1:0] idx;
    idx = 2'd0;
    if (r[1]) idx = 2'd1;
    if (r[2]) idx = 2'd2;
    if (r[3]) idx = 2'd3;
    return idx;
  endfunction

  // Encode a one-hot column vector to its index (input is assumed one-hot).
  function automatic logic [1:0] col_index(input logic [NUM_COLS-1:0] c);
    logic [1:0] idx;
    idx = 2'd0;
    if (c[1]) idx = 2'd1;
    if (c[2]) idx = 2'd2;
    return idx;
  endfunction

  // One-hot key code: bit (row*3 + col).
  function automatic logic [NUM_KEYS-1:0] key_code(input logic [1:0] ri, input logic [1:0] ci);
    logic [3:0] bit_pos;
    bit_pos = (4'(ri) * 4'd3) + 4'(ci);
    return 12'd1 << bit_pos;
  endfunction

endpackage

// File: rtl/keypad_row_sync.sv
// Two-flop synchronizer for the asynchronous keypad row returns.
module row_sync
  import keypad_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_ROWS-1:0] row_in,
  output logic [NUM_ROWS-1:0] row_s
);

  logic [NUM_ROWS-1:0] meta_q;
  logic [NUM_ROWS-1:0] sync_q;

  // Two back-to-back flops; both clear on reset so stale presses are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= row_in;
      sync_q <= meta_q;
    end
  end

  assign row_s = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// Column scanner, debouncer and one-shot key-code emitter for a 3x4 keypad.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 4,
  parameter int DEB_CNT  = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  Row,
  output logic [2:0]  Col,
  output logic [11:0] Scan_data,
  output logic        valid
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(DEB_CNT - 1);

  logic [3:0]  row_s;
  state_e      state_q, state_d;
  logic [2:0]  col_q, col_d;
  logic [DW-1:0] dwell_q, dwell_d;
  // Shared between debounce (matching cycles) and release (zero cycles).
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]  row_lat_q, row_lat_d;
  logic [11:0] scan_data_q, scan_data_d;
  logic        valid_q, valid_d;

  row_sync u_row_sync (
    .clk    (clk),
    .rst    (rst),
    .row_in (Row),
    .row_s  (row_s)
  );

  // Next-state logic: scan columns, debounce a single row hit, emit once, wait for release.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    dwell_d     = dwell_q;
    cnt_d       = cnt_q;
    row_lat_d   = row_lat_q;
    scan_data_d = '0;
    valid_d     = 1'b0;
    case (state_q)
      SCAN: begin
        if (dwell_q == DWELL_LAST) begin
          if (is_single_row(row_s)) begin
            // Column stays frozen while this key is qualified.
            row_lat_d = row_s;
            cnt_d     = '0;
            state_d   = DEBOUNCE;
          end else begin
            col_d   = {col_q[1:0], col_q[2]};
            dwell_d = '0;
          end
        end else begin
          dwell_d = dwell_q + DW'(1);
        end
      end
      DEBOUNCE: begin
        if (row_s == row_lat_q) begin
          if (cnt_q == CNT_LAST) begin
            // Output registers load here so the strobe coincides with EMIT.
            state_d     = EMIT;
            scan_data_d = key_code(row_index(row_lat_q), col_index(col_q));
            valid_d     = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          state_d = SCAN;
          col_d   = {col_q[1:0], col_q[2]};
          dwell_d = '0;
        end
      end
      EMIT: begin
        state_d = WAIT_RELEASE;
        cnt_d   = '0;
      end
      WAIT_RELEASE: begin
        if (row_s == 4'b0000) begin
          if (cnt_q == CNT_LAST) begin
            state_d = SCAN;
            col_d   = {col_q[1:0], col_q[2]};
            dwell_d = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          cnt_d = '0;
        end
      end
      default: begin
        state_d = SCAN;
      end
    endcase
  end

  // State and output registers; reset abandons any press in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= SCAN;
      col_q       <= COL_RESET;
      dwell_q     <= '0;
      cnt_q       <= '0;
      row_lat_q   <= '0;
      scan_data_q <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      dwell_q     <= dwell_d;
      cnt_q       <= cnt_d;
      row_lat_q   <= row_lat_d;
      scan_data_q <= scan_data_d;
      valid_q     <= valid_d;
    end
  end

  assign Col       = col_q;
  assign Scan_data = scan_data_q;
  assign valid     = valid_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad model, directed scenarios, then random presses.
module tb_keypad_scanner;
  import keypad_pkg::*;

  localparam int SCAN_DIV = 4;
  localparam int DEB_CNT  = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  Row;
  logic [2:0]  Col;
  logic [11:0] Scan_data;
  logic        valid;

  // One bit per key, indexed as in the key code.
  logic [11:0] pressed;
  logic        prev_valid;

  int checks   = 0;
  int failures = 0;

  logic [11:0] exp_q[$];
  logic [11:0] got_q[$];

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Keypad model: a pressed key connects its column drive to its row return.
  always_comb begin
    Row = '0;
    for (int r = 0; r < 4; r++) begin
      Row[r] = |(pressed[r*3 +: 3] & Col);
    end
  end

  keypad_scanner #(
    .SCAN_DIV (SCAN_DIV),
    .DEB_CNT  (DEB_CNT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .Row       (Row),
    .Col       (Col),
    .Scan_data (Scan_data),
    .valid     (valid)
  );

  // Driver / checker tasks
  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Advance to the next falling edge; check strobe shape and record pulses.
  task automatic tick();
    @(negedge clk);
    chk("valid_back_to_back", {11'b0, valid & prev_valid}, 12'h000);
    if (!valid) chk("data_idle", Scan_data, 12'h000);
    if (valid === 1'b1) got_q.push_back(Scan_data);
    prev_valid = valid;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_col(input logic [2:0] c, input string tag);
    int n;
    n = 0;
    while (Col !== c && n < 100) begin
      tick();
      n++;
    end
    chk(tag, {9'b0, Col}, {9'b0, c});
  endtask

  // Scoreboard: compare recorded pulses with the expected queue, then clear both.
  task automatic check_pulses(input string tag);
    chk({tag, "_count"}, 12'(got_q.size()), 12'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      chk({tag, "_code"}, got_q.pop_front(), exp_q.pop_front());
    end
    got_q.delete();
    exp_q.delete();
  endtask

  function automatic logic [11:0] code_of(input int r, input int c);
    logic [11:0] one;
    one = 12'h001;
    return one << (r * 3 + c);
  endfunction

  initial begin
    int n;
    int k;
    int r;
    int c;
    int r2;

    pressed    = '0;
    prev_valid = 1'b0;
    rst        = 1'b0;

    // Reset values, taken before any clock edge while reset is high.
    #2 rst = 1'b1;
    #1;
    chk("reset_col", {9'b0, Col}, 12'h001);
    chk("reset_data", Scan_data, 12'h000);
    chk("reset_valid", {11'b0, valid}, 12'h000);
    #9 rst = 1'b0;
    ticks(SCAN_DIV - 1);
    chk("col_hold_after_reset", {9'b0, Col}, 12'h001);
    tick();
    chk("col_step_after_reset", {9'b0, Col}, 12'h002);

    // Key '1' held for 300 ns: one pulse, no repeat.
    pressed[0] = 1'b1;
    exp_q.push_back(code_of(0, 0));
    ticks(30);
    pressed = '0;
    ticks(DEB_CNT + 6);
    check_pulses("key1");
    wait_col(3'b010, "key1_resume_col1");
    wait_col(3'b100, "key1_resume_col2");

    // Key '#': pulse arrives a fixed time after column 2 is driven.
    wait_col(3'b001, "hash_start");
    pressed[KEY_HASH] = 1'b1;
    wait_col(3'b100, "hash_col2");
    n = 0;
    while (valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("hash_latency", 12'(n), 12'((SCAN_DIV - 1) + DEB_CNT + 1));
    exp_q.push_back(code_of(3, 2));
    ticks(20);
    pressed = '0;
    ticks(DEB_CNT + 6);
    check_pulses("hash");

    // Key '5' bounces during debounce: rejected, column advances.
    wait_col(3'b001, "bounce_start");
    pressed[4] = 1'b1;
    wait_col(3'b010, "bounce_col1");
    ticks(SCAN_DIV);
    pressed[4] = 1'b0;
    tick();
    pressed[4] = 1'b1;
    ticks(2);
    chk("bounce_col_advance", {9'b0, Col}, 12'h004);
    check_pulses("bounce_reject");
    exp_q.push_back(code_of(1, 1));
    ticks(30);
    pressed = '0;
    ticks(DEB_CNT + 6);
    check_pulses("bounce_clean");

    // Keys '1' and '4' share a column: ignored until '4' is released.
    pressed[0] = 1'b1;
    pressed[3] = 1'b1;
    ticks(40);
    check_pulses("multi_ignored");
    pressed[3] = 1'b0;
    exp_q.push_back(code_of(0, 0));
    ticks(30);
    pressed = '0;
    ticks(DEB_CNT + 6);
    check_pulses("multi_release");

    // Reset during debounce of '0': column snaps back at once, no pulse later.
    wait_col(3'b001, "rstmid_start");
    pressed[KEY_0] = 1'b1;
    wait_col(3'b010, "rstmid_col1");
    ticks(SCAN_DIV + 1);
    #2 rst = 1'b1;
    #1;
    chk("rstmid_col", {9'b0, Col}, 12'h001);
    chk("rstmid_valid", {11'b0, valid}, 12'h000);
    chk("rstmid_data", Scan_data, 12'h000);
    ticks(3);
    pressed = '0;
    ticks(3);
    rst = 1'b0;
    ticks(20);
    check_pulses("rstmid");

    // Random presses: single keys give one code each, same-column pairs give none.
    for (int it = 0; it < 16; it++) begin
      k = $urandom_range(0, 11);
      r = k / 3;
      c = k % 3;
      if ($urandom_range(0, 3) == 0) begin
        r2 = (r + 1 + $urandom_range(0, 2)) % 4;
        pressed[r * 3 + c]  = 1'b1;
        pressed[r2 * 3 + c] = 1'b1;
      end else begin
        pressed[k] = 1'b1;
        exp_q.push_back(code_of(r, c));
      end
      ticks($urandom_range(30, 60));
      pressed = '0;
      ticks($urandom_range(10, 20));
    end
    check_pulses("random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
